// File: rtl/uart_rx_fifo.sv
// UART receiver (mid-bit sampling, start-glitch rejection) feeding a show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to add the parity_odd input and a parity check state.
module uart_rx_fifo #(
  parameter int unsigned MAX_DATA_BITS = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned PERIOD_W      = 14
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [3:0]                    data_size,
  input  logic [PERIOD_W-1:0]           bit_period,
  input  logic                          serial_in,
  input  logic                          data_read,
`ifdef UART_RX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic [MAX_DATA_BITS-1:0]      rx_data,
  output logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun_error,
  output logic                          framing_error,
  output logic                          parity_error
);

  localparam int unsigned      PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned      CntW    = PtrW + 1;
  localparam logic [4:0]       MaxBits = 5'(MAX_DATA_BITS);
  localparam logic [CntW-1:0]  Full    = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StLoad} state_e;

  state_e                     state_q, state_d;
  logic                       sync1_q, sync2_q, line_prev_q;
  logic [PERIOD_W-1:0]        period_q, period_d, timer_q, timer_d;
  logic [4:0]                 size_q, size_d, idx_q, idx_d, size_clamped;
  logic [MAX_DATA_BITS-1:0]   shift_q, shift_d;
  logic                       framing_q, framing_d;
  logic                       start, tick, push;

  // Serial line synchroniser; line_prev_q gives the falling-edge reference.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
    end else begin
      sync1_q     <= serial_in;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
    end
  end

  assign start = (state_q == StIdle) && line_prev_q && !sync2_q;
  assign tick  = (timer_q == PERIOD_W'(1));

  always_comb begin
    size_clamped = {1'b0, data_size};
    if (size_clamped < 5'd5)         size_clamped = 5'd5;
    else if (size_clamped > MaxBits) size_clamped = MaxBits;
  end

`ifdef UART_RX_PARITY_EN
  logic parity_odd_q, parity_odd_d, parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    period_d  = period_q;
    size_d    = size_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    framing_d = framing_q;
    push      = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_odd_d = parity_odd_q;
    parity_err_d = parity_err_q;
`endif
    if (state_q != StIdle && state_q != StLoad) begin
      timer_d = tick ? period_q : timer_q - PERIOD_W'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StStart;
          timer_d  = bit_period >> 1;
          period_d = bit_period;
          size_d   = size_clamped;
          idx_d    = '0;
          shift_d  = '0;
`ifdef UART_RX_PARITY_EN
          parity_odd_d = parity_odd;
`endif
        end
      end
      StStart: if (tick) state_d = sync2_q ? StIdle : StData;
      StData: begin
        if (tick) begin
          for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
            if (idx_q == 5'(i)) shift_d[i] = sync2_q;
          end
          if (idx_q == size_q - 5'd1) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          // Expected bit makes the total count of ones odd when parity_odd is set.
          parity_err_d = sync2_q != (^shift_q ^ parity_odd_q);
          state_d      = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          framing_d = !sync2_q;
          state_d   = sync2_q ? StLoad : StIdle;
        end
      end
      StLoad: begin
        push    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      period_q  <= '0;
      size_q    <= 5'd5;
      idx_q     <= '0;
      shift_q   <= '0;
      framing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      size_q    <= size_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      framing_q <= framing_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parity_odd_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_odd_q <= parity_odd_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_error = parity_err_q;
`else
  assign parity_error = 1'b0;
`endif

  // Receive FIFO
  logic [MAX_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]          count_q, count_d;
  logic                     overrun_q, overrun_d;
  logic                     pop, full, wr_en;

  assign pop   = data_read && (count_q != '0);
  assign full  = (count_q == Full);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CntW'(1);
    else if (!wr_en && pop) count_d = count_q - CntW'(1);
    overrun_d = overrun_q;
    if (push && full && !pop)  overrun_d = 1'b1;
    else if (pop && overrun_q) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_ready    = (count_q != '0);
  assign rx_data       = data_ready ? mem[rd_ptr_q] : '0;
  assign fifo_count    = count_q;
  assign overrun_error = overrun_q;
  assign framing_error = framing_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, corner-case sequences and
// randomized frames scored against a frame-level queue model.
module tb_uart_rx_fifo;
  localparam int MaxBits = 8;
  localparam int Depth   = 4;
  localparam int PW      = 14;
`ifdef UART_RX_PARITY_EN
  localparam bit HasPar = 1'b1;
`else
  localparam bit HasPar = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               n_rst = 1'b0;
  logic [3:0]         data_size = 4'd8;
  logic [PW-1:0]      bit_period = PW'(10);
  logic               serial_in = 1'b1;
  logic               data_read = 1'b0;
  logic               p_odd = 1'b0;
  logic [MaxBits-1:0] rx_data;
  logic               data_ready;
  logic [$clog2(Depth):0] fifo_count;
  logic               overrun_error, framing_error, parity_error;

  uart_rx_fifo #(.MAX_DATA_BITS(MaxBits), .FIFO_DEPTH(Depth), .PERIOD_W(PW)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .data_size    (data_size),
    .bit_period   (bit_period),
    .serial_in    (serial_in),
    .data_read    (data_read),
`ifdef UART_RX_PARITY_EN
    .parity_odd   (p_odd),
`endif
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .fifo_count   (fifo_count),
    .overrun_error(overrun_error),
    .framing_error(framing_error),
    .parity_error (parity_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Frame-level reference model.
  logic [15:0] mq[$];
  bit m_over = 0, m_frame = 0, m_par = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int eff_size(input int s);
    if (s < 5) return 5;
    if (s > MaxBits) return MaxBits;
    return s;
  endfunction

  function automatic logic [15:0] masked(input int s, input logic [15:0] v);
    logic [15:0] m;
    m = 16'((32'd1 << eff_size(s)) - 1);
    return v & m;
  endfunction

  // All stimulus changes on the falling edge; the DUT samples on the rising edge.
  task automatic send_frame(input int sz, input logic [15:0] val, input bit stop,
                            input int period, input bit scramble, input bit pbit);
    int n;
    n = eff_size(sz);
    data_size  = 4'(sz);
    bit_period = PW'(period);
    serial_in  = 1'b0;
    repeat (period) @(negedge clk);
    if (scramble) begin
      data_size  = 4'($urandom);
      bit_period = PW'($urandom_range(4, 40));
      p_odd      = ~p_odd;
    end
    for (int i = 0; i < n; i++) begin
      serial_in = val[i];
      repeat (period) @(negedge clk);
    end
    if (HasPar) begin
      serial_in = pbit;
      repeat (period) @(negedge clk);
    end
    serial_in = stop;
    repeat (period) @(negedge clk);
    serial_in = 1'b1;
    repeat (period + 4) @(negedge clk);
  endtask

  task automatic model_frame(input int sz, input logic [15:0] val, input bit stop,
                             input bit pbit, input bit odd);
    logic [15:0] d;
    d = masked(sz, val);
    if (HasPar) m_par = (pbit != (^d ^ odd));
    if (stop) begin
      m_frame = 1'b0;
      if (mq.size() < Depth) mq.push_back(d);
      else m_over = 1'b1;
    end else begin
      m_frame = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"},   32'(fifo_count), 32'(mq.size()));
    check({tag, ".ready"},   32'(data_ready), 32'(mq.size() != 0));
    check({tag, ".rx_data"}, 32'(rx_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check({tag, ".overrun"}, 32'(overrun_error), 32'(m_over));
    check({tag, ".framing"}, 32'(framing_error), 32'(m_frame));
    check({tag, ".parity"},  32'(parity_error), 32'(m_par));
  endtask

  task automatic read_one(input string tag);
    check_state(tag);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    if (mq.size() != 0) begin
      void'(mq.pop_front());
      m_over = 1'b0;
    end
  endtask

  typedef struct {
    int          size;
    logic [15:0] val;
    bit          stop;
    logic [15:0] exp_data;
    bit          exp_push;
    bit          exp_fe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8,  16'h00A5, 1'b1, 16'h00A5, 1'b1, 1'b0};
    vecs[1] = '{5,  16'h001F, 1'b1, 16'h001F, 1'b1, 1'b0};
    vecs[2] = '{3,  16'h001A, 1'b1, 16'h001A, 1'b1, 1'b0};
    vecs[3] = '{15, 16'h01C3, 1'b1, 16'h00C3, 1'b1, 1'b0};
    vecs[4] = '{8,  16'h003C, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{8,  16'h005A, 1'b1, 16'h005A, 1'b1, 1'b0};
    vecs[6] = '{6,  16'h002B, 1'b1, 16'h002B, 1'b1, 1'b0};
    vecs[7] = '{8,  16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check_state("reset");
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check_state("post_reset");

    // Vector table at bit_period 10
    foreach (vecs[k]) begin
      send_frame(vecs[k].size, vecs[k].val, vecs[k].stop, 10, 1'b0, 1'b0);
      model_frame(vecs[k].size, vecs[k].val, vecs[k].stop, 1'b0, p_odd);
      check($sformatf("vec%0d.count", k), 32'(fifo_count), 32'(vecs[k].exp_push));
      if (vecs[k].exp_push)
        check($sformatf("vec%0d.data", k), 32'(rx_data), 32'(vecs[k].exp_data));
      check($sformatf("vec%0d.framing", k), 32'(framing_error), 32'(vecs[k].exp_fe));
      if (vecs[k].exp_push) read_one($sformatf("vec%0d.rd", k));
    end

    // Overrun: five frames into four entries, head stays frame 1
    for (int i = 1; i <= 5; i++) begin
      send_frame(8, 16'(i * 16'h11), 1'b1, 10, 1'b0, 1'b0);
      model_frame(8, 16'(i * 16'h11), 1'b1, 1'b0, p_odd);
    end
    check("ovr.count", 32'(fifo_count), 32'd4);
    check("ovr.flag", 32'(overrun_error), 32'd1);
    check("ovr.head", 32'(rx_data), 32'h11);
    read_one("ovr.rd0");
    check("ovr.cleared", 32'(overrun_error), 32'd0);
    check("ovr.head1", 32'(rx_data), 32'h22);
    for (int i = 0; i < 3; i++) read_one("ovr.drain");
    read_one("underflow");
    check_state("underflow.after");

    // Start-bit glitch: 3 low cycles then idle
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (30) @(negedge clk);
    check_state("glitch");
    send_frame(8, 16'h6E, 1'b1, 10, 1'b0, 1'b0);
    model_frame(8, 16'h6E, 1'b1, 1'b0, p_odd);
    check("glitch.next", 32'(rx_data), 32'h6E);
    check_state("glitch.next");

    // Reset mid-frame aborts and empties the FIFO
    serial_in = 1'b0;
    repeat (25) @(negedge clk);
    n_rst = 1'b0;
    serial_in = 1'b1;
    @(negedge clk);
    mq.delete();
    m_over = 0; m_frame = 0; m_par = 0;
    check_state("midreset");
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(7, 16'h55, 1'b1, 10, 1'b0, 1'b0);
    model_frame(7, 16'h55, 1'b1, 1'b0, p_odd);
    check_state("midreset.next");
    read_one("midreset.rd");

`ifdef UART_RX_PARITY_EN
    p_odd = 1'b0;
    send_frame(8, 16'h07, 1'b1, 10, 1'b0, 1'b0);
    model_frame(8, 16'h07, 1'b1, 1'b0, 1'b0);
    check("par.flag", 32'(parity_error), 32'd1);
    check("par.data", 32'(rx_data), 32'h07);
    read_one("par.rd");
`endif

    // Randomized frames with captured-config scrambling mid-frame
    for (int f = 0; f < 60; f++) begin
      int sz, per, nrd;
      logic [15:0] v;
      bit st, pb, odd;
      sz  = $urandom_range(0, 15);
      v   = 16'($urandom);
      st  = ($urandom_range(0, 7) != 0);
      per = $urandom_range(4, 16);
      pb  = 1'($urandom);
      odd = p_odd;
      send_frame(sz, v, st, per, 1'b1, pb);
      model_frame(sz, v, st, pb, odd);
      check_state($sformatf("rnd%0d", f));
      nrd = $urandom_range(0, 3);
      for (int r = 0; r < nrd; r++) read_one($sformatf("rnd%0d.rd", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
